// File: rtl/gpu_pkg.sv
// gpu_pkg: constants shared by the GPU command dispatcher and its buffer.
//   - command word layout ({addr[3:0], data[31:0]})
//   - control opcodes, parameter-register write addresses, status read addresses
//   - parameter field widths and the saturating error-counter helper
package gpu_pkg;

  localparam int CMD_AW   = 4;
  localparam int DATA_W   = 32;
  localparam int CMD_W    = CMD_AW + DATA_W;

  localparam int COLOR_W  = 16;
  localparam int A_W      = 19;
  localparam int B_W      = 24;
  localparam int W_W      = 32;
  localparam int ADDR_W   = 32;
  localparam int STRIDE_W = 16;
  localparam int SEQ_W    = 32;
  localparam int ERR_W    = 16;

  // Control opcodes carried in data[3:0] of an address-0 command.
  // Values 7..15 are deliberately left undefined and decode as illegal.
  typedef enum logic [3:0] {
    OP_START_RASTER = 4'd0,
    OP_WAIT_RASTER  = 4'd1,
    OP_START_WRITE  = 4'd2,
    OP_WAIT_WRITE   = 4'd3,
    OP_WAIT_ALL     = 4'd4,
    OP_SEQ_RESET    = 4'd5,
    OP_FENCE        = 4'd6
  } opcode_e;

  // Command write addresses
  localparam logic [CMD_AW-1:0] REG_CTRL   = 4'd0;
  localparam logic [CMD_AW-1:0] REG_COLOR  = 4'd1;
  localparam logic [CMD_AW-1:0] REG_A01    = 4'd2;
  localparam logic [CMD_AW-1:0] REG_A12    = 4'd3;
  localparam logic [CMD_AW-1:0] REG_A20    = 4'd4;
  localparam logic [CMD_AW-1:0] REG_W0     = 4'd5;
  localparam logic [CMD_AW-1:0] REG_W1     = 4'd6;
  localparam logic [CMD_AW-1:0] REG_W2     = 4'd7;
  localparam logic [CMD_AW-1:0] REG_ADDR   = 4'd8;
  localparam logic [CMD_AW-1:0] REG_STRIDE = 4'd9;
  localparam logic [CMD_AW-1:0] REG_B01    = 4'd10;
  localparam logic [CMD_AW-1:0] REG_B12    = 4'd11;
  localparam logic [CMD_AW-1:0] REG_B20    = 4'd12;

  // Status read addresses
  localparam logic [CMD_AW-1:0] STAT_SEQ   = 4'd0;
  localparam logic [CMD_AW-1:0] STAT_USED  = 4'd1;
  localparam logic [CMD_AW-1:0] STAT_FLAGS = 4'd2;
  localparam logic [CMD_AW-1:0] STAT_ERR   = 4'd3;
  localparam logic [CMD_AW-1:0] STAT_IRQ   = 4'd4;

  // Error counter sticks at all-ones rather than wrapping back to zero.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// gpu_cmd_fifo: show-ahead command buffer, DEPTH x W.
//   clk, resetn    : clock, asynchronous active-low reset (empties the buffer)
//   push/push_data : write one entry (ignored when full)
//   pop            : drop the head entry (ignored when empty)
//   head           : current head entry, valid whenever !empty
//   empty/full     : occupancy flags
//   used           : number of entries held (0..DEPTH)
module gpu_cmd_fifo #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 36
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   used
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   used_q, used_d;
  logic          do_push, do_pop;

  assign empty   = (used_q == '0);
  assign full    = (used_q == (AW+1)'(DEPTH));
  assign used    = used_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Combinational read of the head gives the show-ahead behaviour: an entry
  // pushed into an empty buffer is presented as soon as the pointers update.
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    used_d   = used_q;
    case ({do_push, do_pop})
      2'b10:   used_d = used_q + 1'b1;
      2'b01:   used_d = used_q - 1'b1;
      default: used_d = used_q;
    endcase
  end

  // Storage has no reset; emptiness is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
    end
  end

endmodule

// File: rtl/gpu_cmd_dispatch.sv
// gpu_cmd_dispatch: Avalon-fed command dispatcher for the render/write channels.
//   clk, resetn            : clock, asynchronous active-low reset
//   slave_address/write_*  : command push {address, data} into the buffer
//   slave_wait_request     : write stalled because the buffer is full
//   slave_read_en/_data    : status reads (seq_no, used, flags, err_cnt, irq)
//   rend_start/rend_done   : per-channel renderer start pulse / idle flag
//   wr_start/wr_busy       : per-channel writer start pulse / busy flag
//   p_*                    : parameter set loaded by non-control commands
//   irq                    : fence interrupt, level, cleared by reading status 4
module gpu_cmd_dispatch
  import gpu_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int CB_DEPTH = 256,
  parameter int CB_AW    = $clog2(CB_DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [CMD_AW-1:0]     slave_address,
  input  logic                  slave_write_en,
  input  logic [DATA_W-1:0]     slave_write_data,
  input  logic                  slave_read_en,
  output logic [DATA_W-1:0]     slave_read_data,
  output logic                  slave_wait_request,
  output logic [NUM_CH-1:0]     rend_start,
  input  logic [NUM_CH-1:0]     rend_done,
  output logic [NUM_CH-1:0]     wr_start,
  input  logic [NUM_CH-1:0]     wr_busy,
  output logic [COLOR_W-1:0]    p_color,
  output logic [3*A_W-1:0]      p_a,
  output logic [3*B_W-1:0]      p_b,
  output logic [3*W_W-1:0]      p_w,
  output logic [ADDR_W-1:0]     p_addr,
  output logic [STRIDE_W-1:0]   p_stride,
  output logic                  irq
);

  logic [CMD_W-1:0]  head;
  logic              empty, full, push, pop;
  logic [CB_AW:0]    used;
  logic [CMD_AW-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  opcode_e           op;
  logic [3:0]        ch;
  logic              ch_ok, ch_done, ch_busy, illegal, seq_clr, fence;
  logic [NUM_CH-1:0] ch_onehot;

  logic [COLOR_W-1:0]  color_q, color_d;
  logic [3*A_W-1:0]    a_q, a_d;
  logic [3*B_W-1:0]    b_q, b_d;
  logic [3*W_W-1:0]    w_q, w_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [STRIDE_W-1:0] stride_q, stride_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                irq_q, irq_d;

  assign push               = slave_write_en && !full;
  assign slave_wait_request = slave_write_en && full;

  gpu_cmd_fifo #(
    .DEPTH (CB_DEPTH),
    .AW    (CB_AW),
    .W     (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data ({slave_address, slave_write_data}),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .used      (used)
  );

  assign head_addr = head[CMD_W-1:DATA_W];
  assign head_data = head[DATA_W-1:0];
  assign op        = opcode_e'(head_data[3:0]);
  assign ch        = head_data[7:4];

  // Channel select; ch_ok stays low for ch >= NUM_CH, so out-of-range
  // channels never index the per-channel status vectors.
  always_comb begin
    ch_ok     = 1'b0;
    ch_done   = 1'b0;
    ch_busy   = 1'b0;
    ch_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(ch) == i) begin
        ch_ok        = 1'b1;
        ch_done      = rend_done[i];
        ch_busy      = wr_busy[i];
        ch_onehot[i] = 1'b1;
      end
    end
  end

  // Head execution: every command either completes (pops) this cycle or
  // stalls with the head left in place.
  always_comb begin
    pop        = 1'b0;
    illegal    = 1'b0;
    seq_clr    = 1'b0;
    fence      = 1'b0;
    rend_start = '0;
    wr_start   = '0;
    color_d    = color_q;
    a_d        = a_q;
    b_d        = b_q;
    w_d        = w_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    err_d      = err_q;
    irq_d      = irq_q;
    seq_d      = seq_q;

    if (!empty) begin
      if (head_addr == REG_CTRL) begin
        case (op)
          OP_START_RASTER: begin
            if (!ch_ok) illegal = 1'b1;
            else if (ch_done && !ch_busy) begin
              pop        = 1'b1;
              rend_start = ch_onehot;
            end
          end
          OP_WAIT_RASTER: begin
            if (!ch_ok) illegal = 1'b1;
            else if (ch_done) pop = 1'b1;
          end
          OP_START_WRITE: begin
            if (!ch_ok) illegal = 1'b1;
            else if (ch_done && !ch_busy) begin
              pop      = 1'b1;
              wr_start = ch_onehot;
            end
          end
          OP_WAIT_WRITE: begin
            if (!ch_ok) illegal = 1'b1;
            else if (!ch_busy) pop = 1'b1;
          end
          OP_WAIT_ALL: begin
            if ((&rend_done) && !(|wr_busy)) pop = 1'b1;
          end
          OP_SEQ_RESET: begin
            pop     = 1'b1;
            seq_clr = 1'b1;
          end
          OP_FENCE: begin
            pop   = 1'b1;
            fence = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end else begin
        // Parameter writes (and the unused addresses 13..15) always complete.
        pop = 1'b1;
        case (head_addr)
          REG_COLOR:  color_d               = head_data[COLOR_W-1:0];
          REG_A01:    a_d[0*A_W +: A_W]     = head_data[A_W-1:0];
          REG_A12:    a_d[1*A_W +: A_W]     = head_data[A_W-1:0];
          REG_A20:    a_d[2*A_W +: A_W]     = head_data[A_W-1:0];
          REG_W0:     w_d[0*W_W +: W_W]     = head_data;
          REG_W1:     w_d[1*W_W +: W_W]     = head_data;
          REG_W2:     w_d[2*W_W +: W_W]     = head_data;
          REG_ADDR:   addr_d                = head_data;
          REG_STRIDE: stride_d              = head_data[STRIDE_W-1:0];
          REG_B01:    b_d[0*B_W +: B_W]     = head_data[B_W-1:0];
          REG_B12:    b_d[1*B_W +: B_W]     = head_data[B_W-1:0];
          REG_B20:    b_d[2*B_W +: B_W]     = head_data[B_W-1:0];
          default:    ;
        endcase
      end
    end

    if (illegal) begin
      pop   = 1'b1;
      err_d = sat_inc(err_q);
    end

    if (seq_clr)  seq_d = '0;
    else if (pop) seq_d = seq_q + 1'b1;

    // Set after clear so a fence popping alongside the status read survives.
    if (slave_read_en && (slave_address == STAT_IRQ)) irq_d = 1'b0;
    if (fence) irq_d = 1'b1;
  end

  always_comb begin
    slave_read_data = '0;
    case (slave_address)
      STAT_SEQ:   slave_read_data = seq_q;
      STAT_USED:  slave_read_data = DATA_W'(used);
      STAT_FLAGS: slave_read_data = DATA_W'({rend_done, wr_busy});
      STAT_ERR:   slave_read_data = DATA_W'(err_q);
      STAT_IRQ:   slave_read_data = DATA_W'(irq_q);
      default:    slave_read_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      color_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      w_q      <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      seq_q    <= '0;
      err_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      color_q  <= color_d;
      a_q      <= a_d;
      b_q      <= b_d;
      w_q      <= w_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      seq_q    <= seq_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
    end
  end

  assign p_color  = color_q;
  assign p_a      = a_q;
  assign p_b      = b_q;
  assign p_w      = w_q;
  assign p_addr   = addr_q;
  assign p_stride = stride_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpu_cmd_dispatch.sv
// Directed bench for gpu_cmd_dispatch (NUM_CH=2, CB_DEPTH=256).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
module tb_gpu_cmd_dispatch;

  localparam int NUM_CH   = 2;
  localparam int CB_DEPTH = 256;

  logic               clk = 1'b0;
  logic               resetn;
  logic [3:0]         slave_address;
  logic               slave_write_en;
  logic [31:0]        slave_write_data;
  logic               slave_read_en;
  logic [31:0]        slave_read_data;
  logic               slave_wait_request;
  logic [NUM_CH-1:0]  rend_start, rend_done, wr_start, wr_busy;
  logic [15:0]        p_color;
  logic [56:0]        p_a;
  logic [71:0]        p_b;
  logic [95:0]        p_w;
  logic [31:0]        p_addr;
  logic [15:0]        p_stride;
  logic               irq;

  int vectors = 0;
  int miscompares = 0;
  int rs_cnt = 0;
  int ws_cnt = 0;

  gpu_cmd_dispatch #(.NUM_CH(NUM_CH), .CB_DEPTH(CB_DEPTH)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .slave_address      (slave_address),
    .slave_write_en     (slave_write_en),
    .slave_write_data   (slave_write_data),
    .slave_read_en      (slave_read_en),
    .slave_read_data    (slave_read_data),
    .slave_wait_request (slave_wait_request),
    .rend_start         (rend_start),
    .rend_done          (rend_done),
    .wr_start           (wr_start),
    .wr_busy            (wr_busy),
    .p_color            (p_color),
    .p_a                (p_a),
    .p_b                (p_b),
    .p_w                (p_w),
    .p_addr             (p_addr),
    .p_stride           (p_stride),
    .irq                (irq)
  );

  always #5 clk = ~clk;

  // Count start-pulse bits seen on each falling edge.
  always @(negedge clk) begin
    rs_cnt <= rs_cnt + $countones(rend_start);
    ws_cnt <= ws_cnt + $countones(wr_start);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    slave_address    = a;
    slave_write_data = d;
    slave_write_en   = 1'b1;
    @(posedge clk); #1;
    slave_write_en   = 1'b0;
    $display("write addr=%0d data=%08h", a, d);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    slave_address = a;
    slave_read_en = 1'b1;
    @(negedge clk);
    d = slave_read_data;
    @(posedge clk); #1;
    slave_read_en = 1'b0;
    $display("read  addr=%0d data=%08h", a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d;
    int rs0, ws0;

    resetn = 1'b0;
    slave_address = '0; slave_write_en = 1'b0; slave_write_data = '0;
    slave_read_en = 1'b0;
    rend_done = 2'b11; wr_busy = 2'b00;

    // Reset state
    #1;
    slave_address = 4'd1; #1;
    chk("rst_used", slave_read_data, 0);
    chk("rst_pulses", {rend_start, wr_start}, 0);
    chk("rst_irq", irq, 0);
    chk("rst_color", p_color, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Parameter loads
    wr(4'd1, 32'h0000_1234);
    wr(4'd8, 32'h0010_0000);
    idle(3);
    chk("color", p_color, 16'h1234);
    chk("addr", p_addr, 32'h0010_0000);
    rd(4'd0, d); chk("seq_after_params", d, 2);
    wr(4'd2, 32'h0007_0001);
    wr(4'd4, 32'hFFFF_FFFF);
    wr(4'd7, 32'hDEAD_BEEF);
    wr(4'd12, 32'hFFAB_CDEF);
    wr(4'd9, 32'h1234_5678);
    wr(4'd13, 32'h0000_0055);
    idle(3);
    chk("p_a", p_a, {19'h7FFFF, 19'h00000, 19'h70001});
    chk("p_w", p_w, {32'hDEADBEEF, 64'h0});
    chk("p_b", p_b, {24'hABCDEF, 48'h0});
    chk("stride", p_stride, 16'h5678);
    chk("color_kept", p_color, 16'h1234);
    rd(4'd0, d); chk("seq_after_8", d, 8);

    // SEQ_RESET, then START_RASTER ch1 stalled on rend_done[1]
    wr(4'd0, 32'h5);
    idle(2);
    rd(4'd0, d); chk("seq_reset", d, 0);
    rend_done = 2'b01;
    wr(4'd0, 32'h10);
    idle(3);
    @(negedge clk); chk("raster_stall_pulse", rend_start, 2'b00);
    @(posedge clk); #1;
    rd(4'd1, d); chk("raster_stall_used", d, 1);
    rd(4'd0, d); chk("raster_stall_seq", d, 0);
    rs0 = rs_cnt;
    rend_done = 2'b11;
    @(negedge clk); chk("raster_pulse", rend_start, 2'b10);
    @(posedge clk); #1;
    @(negedge clk); chk("raster_pulse_gone", rend_start, 2'b00);
    @(posedge clk); #1;
    idle(2);
    chk("raster_pulse_count", rs_cnt - rs0, 1);
    rd(4'd0, d); chk("raster_seq", d, 1);
    rd(4'd1, d); chk("raster_used", d, 0);

    // Fill while WAIT_WRITE ch0 stalls
    wr_busy = 2'b01;
    wr(4'd0, 32'h3);
    for (int i = 0; i < CB_DEPTH - 1; i++) wr(4'd13, i);
    rd(4'd1, d); chk("fill_used", d, CB_DEPTH);
    slave_address = 4'd13; slave_write_data = 32'hFEED; slave_write_en = 1'b1;
    @(negedge clk); chk("full_wait_1", slave_wait_request, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("full_wait_2", slave_wait_request, 1);
    @(posedge clk); #1;
    wr_busy = 2'b00;
    @(negedge clk); chk("full_wait_3", slave_wait_request, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("full_wait_released", slave_wait_request, 0);
    @(posedge clk); #1;
    slave_write_en = 1'b0;
    idle(270);
    rd(4'd1, d); chk("drain_used", d, 0);
    rd(4'd0, d); chk("drain_seq", d, 258);

    // Illegal commands, then a legal START_WRITE
    rs0 = rs_cnt; ws0 = ws_cnt;
    wr(4'd0, 32'h5);
    wr(4'd0, 32'h0F);
    wr(4'd0, 32'h30);
    idle(3);
    rd(4'd3, d); chk("err_cnt", d, 2);
    rd(4'd0, d); chk("illegal_seq", d, 2);
    chk("illegal_no_pulse", (rs_cnt - rs0) + (ws_cnt - ws0), 0);
    wr(4'd0, 32'h02);
    idle(3);
    chk("write_pulse_count", ws_cnt - ws0, 1);
    rd(4'd0, d); chk("write_seq", d, 3);

    // FENCE pop coinciding with status read of irq
    wr(4'd0, 32'h6);
    rd(4'd4, d); chk("fence_read_old", d, 0);
    @(negedge clk); chk("fence_wins", irq, 1);
    @(posedge clk); #1;
    rd(4'd4, d); chk("irq_read", d, 1);
    @(negedge clk); chk("irq_cleared", irq, 0);
    @(posedge clk); #1;

    // Reset during a WAIT_ALL stall with 5 queued
    wr(4'd0, 32'h6);
    idle(2);
    chk("irq_before_reset", irq, 1);
    wr_busy = 2'b10;
    wr(4'd0, 32'h4);
    wr(4'd1, 32'h0000_AAAA);
    wr(4'd8, 32'h1);
    wr(4'd3, 32'h5);
    wr(4'd13, 32'h0);
    idle(2);
    rd(4'd1, d); chk("wait_all_used", d, 5);
    resetn = 1'b0;
    slave_address = 4'd1; #1;
    chk("rst2_used", slave_read_data, 0);
    slave_address = 4'd0; #1;
    chk("rst2_seq", slave_read_data, 0);
    slave_address = 4'd3; #1;
    chk("rst2_err", slave_read_data, 0);
    chk("rst2_irq", irq, 0);
    chk("rst2_params", {p_color, p_addr, p_stride, p_a, p_b, p_w}, 0);
    chk("rst2_pulses", {rend_start, wr_start}, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    wr_busy = 2'b00;
    idle(4);
    rd(4'd1, d); chk("post_rst_used", d, 0);
    rd(4'd0, d); chk("post_rst_seq", d, 0);
    chk("post_rst_color", p_color, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpu_cmd_dispatch.md
GPU_CMD_DISPATCH -- requirements
Module: gpu_cmd_dispatch

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of render/write channels (1..8).
REQ-002 SHALL have parameter CB_DEPTH, default 256, command buffer depth in entries (power of two, >=4).
REQ-003 SHALL have parameter CB_AW, default log2(CB_DEPTH), command buffer address width.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port resetn  in  1  reset (asynchronous, active-low).
REQ-006 SHALL have ports slave_address in 4, slave_write_en in 1 and slave_write_data in 32: the Avalon command write path.
REQ-007 SHALL have ports slave_read_en in 1 and slave_read_data out 32: the Avalon status read path.
REQ-008 SHALL have port slave_wait_request  out  1  write stall.
REQ-009 SHALL have ports rend_start out NUM_CH (1-cycle start pulse per channel) and rend_done in NUM_CH (renderer idle).
REQ-010 SHALL have ports wr_start out NUM_CH (1-cycle writer start pulse) and wr_busy in NUM_CH (tile drain/RAM write active).
REQ-011 SHALL have parameter-set output ports: p_color 16, p_a 57 ({A20,A12,A01} 19 b each), p_b 72 ({B20,B12,B01} 24 b each), p_w 96 ({w2,w1,w0}), p_addr 32, p_stride 16.
REQ-012 SHALL have port irq  out  1  fence interrupt, level.

Function
REQ-013 SHALL push {slave_address, slave_write_data} (36 b) into the command buffer when slave_write_en && !full; slave_wait_request = slave_write_en && full, combinational.
REQ-014 SHALL present the buffer head show-ahead; an entry written into an empty buffer becomes visible the next cycle.
REQ-015 SHALL pop the head only on a cycle where the command completes; pop and push in the same cycle SHALL leave the used count unchanged.
REQ-016 SHALL on pop of an entry with addr 1..12 load: 1 color[15:0], 2-4 A01/A12/A20[18:0], 5-7 w0/w1/w2, 8 addr, 9 stride[15:0], 10-12 B01/B12/B20[23:0]; addr 13-15 SHALL pop with no effect.
REQ-017 SHALL decode addr 0 as control: opcode = data[3:0], channel ch = data[7:4].
REQ-018 SHALL implement op 0 START_RASTER: pop and pulse rend_start[ch] iff rend_done[ch] && !wr_busy[ch], else stall.
REQ-019 SHALL implement op 1 WAIT_RASTER: stall until rend_done[ch].
REQ-020 SHALL implement op 2 START_WRITE: pop and pulse wr_start[ch] iff rend_done[ch] && !wr_busy[ch], else stall.
REQ-021 SHALL implement op 3 WAIT_WRITE: stall until !wr_busy[ch].
REQ-022 SHALL implement op 4 WAIT_ALL: stall until all rend_done=1 and all wr_busy=0.
REQ-023 SHALL implement op 5 SEQ_RESET: pop and clear seq_no.
REQ-024 SHALL implement op 6 FENCE: pop and set irq pending.
REQ-025 SHALL treat ops 7-15, or ops 0-3 with ch>=NUM_CH, as illegal: pop, no pulse, err_cnt+1 saturating at 0xFFFF.
REQ-026 SHALL increment seq_no (32 b, wraps) on every pop except SEQ_RESET; a SEQ_RESET pop SHALL yield 0.
REQ-027 SHALL drive rend_start/wr_start combinationally in the pop cycle, one pulse per popped command.
REQ-028 SHALL read combinationally: addr 0 seq_no, 1 used count, 2 {rend_done, wr_busy} packed low bits, 3 err_cnt, 4 irq pending, others 0.
REQ-029 SHALL clear irq when slave_read_en && address==4; a FENCE pop in the same cycle SHALL win (irq stays 1).

Reset
REQ-030 SHALL, on resetn low, asynchronously clear buffer (empty, used 0), all parameter registers, seq_no, err_cnt, irq; pulses SHALL be 0 during reset.
REQ-031 SHALL, on reset mid-stall, discard the head entry and all queued entries.

Structure
REQ-032 SHALL take opcode, register-address and field-width constants from shared package gpu_pkg.
REQ-033 SHALL implement the buffer as sub-module gpu_cmd_fifo (show-ahead, CB_DEPTH x 36, used-count output).

Verification
REQ-034 SHALL verify: write addr1=0x1234, addr8=0x00100000 -> p_color=0x1234, p_addr=0x00100000, seq_no=2.
REQ-035 SHALL verify: rend_done[1]=0, push START_RASTER ch1 (0x10) -> stall, no pulse; rend_done[1]=1 -> single rend_start=2'b10, seq_no+1.
REQ-036 SHALL verify: fill CB_DEPTH entries while stalled by WAIT_WRITE -> used=CB_DEPTH, extra write sees wait_request=1 until one pop.
REQ-037 SHALL verify: push 0x0F then 0x30 (ch3, NUM_CH=2) -> err_cnt=2, no pulses, seq_no=2.
REQ-038 SHALL verify: FENCE popped same cycle as read of addr 4 -> irq=1; a later read returns 1, then irq=0.
REQ-039 SHALL verify: resetn low during WAIT_ALL stall with 5 queued -> used=0, seq_no=0, all outputs 0.
